// File: rtl/irda_fir_pkg.sv
// Shared definitions for the FIR 4PPM receive path: FSM encoding, 4PPM symbols,
// CRC-32 constants and small helper functions.
package irda_fir_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;

  // Chip patterns, first chip received in the MSB.
  localparam logic [3:0] SYM_00 = 4'b1000;
  localparam logic [3:0] SYM_01 = 4'b0100;
  localparam logic [3:0] SYM_10 = 4'b0010;
  localparam logic [3:0] SYM_11 = 4'b0001;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Returns {legal, dibit}.
  function automatic logic [2:0] ppm4_decode(input logic [3:0] pat);
    case (pat)
      SYM_00:  return 3'b100;
      SYM_01:  return 3'b101;
      SYM_10:  return 3'b110;
      SYM_11:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/irda_crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32 (data consumed LSB first).
module irda_crc32_byte
  import irda_fir_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    crc_out = c;
  end

endmodule

// File: rtl/irda_fir_4ppm_dec.sv
// FIR 4PPM frame decoder behind the flag detector: chips -> bytes with SOF/EOF and
// error status. Define IRDA_FIR_CRC_CHK_EN to add the CRC-32 check and rx_crc_err.
module irda_fir_4ppm_dec
  import irda_fir_pkg::*;
#(
  parameter int BCNT_W    = 12,
  parameter int MAX_BYTES = 2050
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  input  logic              fd_restart,
  input  logic              fir_rx8_enable,
  input  logic              fd_o,
  input  logic              fd_data_bit,
  input  logic              sta_det,
  input  logic              sto_det,
  input  logic              break_det,
  output logic [7:0]        rx_byte,
  output logic              rx_byte_valid,
  output logic              rx_sof,
  output logic              rx_eof,
  output logic              rx_frame_err,
  output logic              rx_sym_err,
  output logic [BCNT_W-1:0] rx_count,
  output logic              rx_active
`ifdef IRDA_FIR_CRC_CHK_EN
  ,
  output logic              rx_crc_err
`endif
);

  logic [1:0]        state, state_n;
  logic [2:0]        chip_sh, chip_sh_n;
  logic [1:0]        chip_cnt, chip_cnt_n;
  logic [1:0]        sym_cnt, sym_cnt_n;
  logic [5:0]        acc, acc_n;
  logic              ferr_q, ferr_n;
  logic              serr_q, serr_n;
  logic [BCNT_W-1:0] count_n;
  logic [7:0]        byte_n;
  logic              valid_n, sof_n, eof_n, ferr_o_n, serr_o_n;
  logic              start;
  logic [2:0]        dec;
  logic [7:0]        byte_full;

  assign dec       = ppm4_decode({chip_sh, fd_o});
  assign byte_full = {dec[1:0], acc};
  assign rx_active = (state == ST_DATA);

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_n    = state;
    chip_sh_n  = chip_sh;
    chip_cnt_n = chip_cnt;
    sym_cnt_n  = sym_cnt;
    acc_n      = acc;
    ferr_n     = ferr_q;
    serr_n     = serr_q;
    count_n    = rx_count;
    byte_n     = rx_byte;
    valid_n    = 1'b0;
    sof_n      = 1'b0;
    eof_n      = 1'b0;
    ferr_o_n   = 1'b0;
    serr_o_n   = 1'b0;
    start      = 1'b0;

    if (fd_restart) begin
      state_n    = ST_IDLE;
      chip_sh_n  = '0;
      chip_cnt_n = '0;
      sym_cnt_n  = '0;
      acc_n      = '0;
      ferr_n     = 1'b0;
      serr_n     = 1'b0;
      count_n    = '0;
      byte_n     = '0;
    end else if (fir_rx8_enable) begin
      case (state)
        ST_IDLE: start = sta_det;
        ST_DATA: begin
          // A data chip concurrent with a stop flag still belongs to the frame.
          if (fd_data_bit && (sto_det || !(break_det || sta_det))) begin
            if (chip_cnt != 2'd3) begin
              chip_sh_n  = {chip_sh[1:0], fd_o};
              chip_cnt_n = chip_cnt + 2'd1;
            end else begin
              chip_cnt_n = '0;
              if (!dec[2]) begin
                serr_n  = 1'b1;
                state_n = ST_SKIP;
              end else begin
                case (sym_cnt)
                  2'd0:    acc_n[1:0] = dec[1:0];
                  2'd1:    acc_n[3:2] = dec[1:0];
                  2'd2:    acc_n[5:4] = dec[1:0];
                  default: ;
                endcase
                sym_cnt_n = sym_cnt + 2'd1;
                if (sym_cnt == 2'd3) begin
                  if (rx_count == BCNT_W'(MAX_BYTES)) begin
                    ferr_n  = 1'b1;
                    state_n = ST_SKIP;
                  end else begin
                    valid_n = 1'b1;
                    sof_n   = (rx_count == '0);
                    byte_n  = byte_full;
                    count_n = rx_count + BCNT_W'(1);
                  end
                end
              end
            end
          end
          if (sto_det) begin
            eof_n    = 1'b1;
            ferr_o_n = ferr_n | ((state_n == ST_DATA) && (chip_cnt_n != '0 || sym_cnt_n != '0));
            serr_o_n = serr_n;
            state_n  = ST_IDLE;
          end else if (break_det || sta_det) begin
            eof_n    = 1'b1;
            ferr_o_n = 1'b1;
            serr_o_n = serr_q;
            state_n  = ST_IDLE;
            start    = sta_det;
          end
        end
        ST_SKIP: begin
          if (sto_det || break_det || sta_det) begin
            eof_n    = 1'b1;
            ferr_o_n = ferr_q | ~sto_det;
            serr_o_n = serr_q;
            state_n  = ST_IDLE;
            start    = sta_det & ~sto_det;
          end
        end
        default: state_n = ST_IDLE;
      endcase

      if (start) begin
        state_n    = ST_DATA;
        chip_cnt_n = '0;
        sym_cnt_n  = '0;
        ferr_n     = 1'b0;
        serr_n     = 1'b0;
        count_n    = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      chip_sh       <= '0;
      chip_cnt      <= '0;
      sym_cnt       <= '0;
      acc           <= '0;
      ferr_q        <= 1'b0;
      serr_q        <= 1'b0;
      rx_count      <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_sym_err    <= 1'b0;
    end else begin
      state         <= state_n;
      chip_sh       <= chip_sh_n;
      chip_cnt      <= chip_cnt_n;
      sym_cnt       <= sym_cnt_n;
      acc           <= acc_n;
      ferr_q        <= ferr_n;
      serr_q        <= serr_n;
      rx_count      <= count_n;
      rx_byte       <= byte_n;
      rx_byte_valid <= valid_n;
      rx_sof        <= sof_n;
      rx_eof        <= eof_n;
      rx_frame_err  <= ferr_o_n;
      rx_sym_err    <= serr_o_n;
    end
  end

`ifdef IRDA_FIR_CRC_CHK_EN
  logic [31:0] crc_q, crc_n, crc_upd;
  logic        crc_err_n;

  irda_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (byte_full),
    .crc_out (crc_upd)
  );

  // The check sees the register after any byte delivered in the stop-flag step.
  always_comb begin
    crc_n = crc_q;
    if (fd_restart || start) crc_n = CRC32_INIT;
    else if (valid_n)        crc_n = crc_upd;
    crc_err_n = eof_n & ~(sto_det && (crc_n == CRC32_RESIDUE) && (count_n >= BCNT_W'(4)));
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      crc_q      <= CRC32_INIT;
      rx_crc_err <= 1'b0;
    end else begin
      crc_q      <= crc_n;
      rx_crc_err <= crc_err_n;
    end
  end
`endif

endmodule

// File: doc/irda_fir_4ppm_dec.md
Name: irda_fir_4ppm_dec

Overview:
- FIR (4 Mb/s) receive stage directly downstream of the FIR flag detector.
- Consumes the detector's chip stream (fd_o qualified by fd_data_bit) and its flag strobes (sta_det, sto_det, break_det).
- Frames each packet, decodes 4PPM chips into bytes and delivers them with valid/SOF/EOF strobes and error status to the receive FIFO/controller.

Parameters:
- BCNT_W, 12, width of the per-frame byte counter and the rx_count output.
- MAX_BYTES, 2050, maximum bytes per frame including FCS; exceeding it is a frame error.

Ports:
- clk  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- fd_restart  in  1  synchronous restart shared with the flag detector; forces IDLE
- fir_rx8_enable  in  1  chip-rate enable; all inputs below are sampled only when high
- fd_o  in  1  chip from the flag detector
- fd_data_bit  in  1  fd_o is a data chip
- sta_det  in  1  start flag detected
- sto_det  in  1  stop flag detected
- break_det  in  1  line-break detected
- rx_byte  out  8  decoded byte
- rx_byte_valid  out  1  one-clk pulse, rx_byte valid
- rx_sof  out  1  with rx_byte_valid on the first byte of a frame
- rx_eof  out  1  one-clk pulse at frame end (good or bad)
- rx_frame_err  out  1  valid with rx_eof: misaligned, overlong or aborted frame
- rx_sym_err  out  1  valid with rx_eof: illegal 4PPM symbol seen
- rx_count  out  BCNT_W  bytes delivered in the current/last frame
- rx_active  out  1  high while in state DATA

Behaviour:
- Reset and fd_restart: all outputs 0; state IDLE; chip, symbol and byte counters 0.
- Work is done only in clk cycles with fir_rx8_enable=1 (the "chip step"). Strobes are registered and appear the clk after the chip step; rx_byte_valid/rx_eof are one clk wide.
- FSM states: IDLE, DATA, SKIP.
  - IDLE: sta_det -> DATA, counters cleared.
  - DATA: shift fd_o into a 4-chip register when fd_data_bit=1. The first data chip after sta_det is chip 0 of symbol 0.
  - After 4 chips, decode (first chip received = MSB of the 4-chip pattern): 1000->00, 0100->01, 0010->10, 0001->11. Any other pattern -> sticky sym_err; state -> SKIP.
  - Byte assembly: dibit of symbol 0 -> byte bits[1:0], symbol 1 -> [3:2], symbol 2 -> [5:4], symbol 3 -> [7:6]. Deliver after symbol 3; rx_count increments; rx_sof on the first byte.
  - sto_det in DATA: process the concurrent data chip first. Then rx_eof. rx_frame_err=1 if the chip or symbol counter is nonzero (partial byte). State -> IDLE.
  - break_det in DATA without sto_det: rx_eof with rx_frame_err=1 -> IDLE.
  - sta_det in DATA (restart): rx_eof with rx_frame_err=1. New frame starts at the same chip step (counters cleared, state stays DATA).
  - Byte count reaching MAX_BYTES+1: that byte is not delivered; rx_frame_err sticky; state -> SKIP.
  - SKIP: discard chips. sto_det, break_det or sta_det -> rx_eof with accumulated errors (rx_frame_err=1 if the trigger is break_det or sta_det). Then IDLE, or DATA for sta_det.
- Simultaneous sto_det and break_det: sto_det wins. fd_restart overrides everything, with no rx_eof.
- rx_count holds its value after rx_eof until the next sta_det.

Optional Feature:
- Macro IRDA_FIR_CRC_CHK_EN.
- Defined:
  - Adds output rx_crc_err (1 bit, valid with rx_eof).
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every delivered byte, FCS included.
  - At sto_det, rx_crc_err=1 unless the residue equals 0xDEBB20E3, or if fewer than 4 bytes were delivered.
  - The CRC register is re-initialised on sta_det.
- Undefined: no port and no CRC logic; EOF status is frame/symbol errors only.

Decomposition:
- Shared package irda_fir_pkg:
  - 4PPM symbol constants and the FSM state encoding.
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE.
- One sub-module, irda_crc32_byte: combinational 8-bit-step CRC-32 next-state function. Instantiated only under IRDA_FIR_CRC_CHK_EN.

Test Plan:
- sta_det, then 8 symbols 1000,0100,0010,0001,0001,0001,0001,0001 and a clean stop -> bytes 0xE4, 0xFF; rx_sof on the first byte; rx_eof with rx_frame_err=0, rx_sym_err=0; rx_count=2.
- Valid frame with a 1100 chip pattern in symbol 5 -> no second byte; rx_eof on sto_det with rx_sym_err=1.
- sta_det, 6 symbols then sto_det -> one byte delivered; rx_eof with rx_frame_err=1 (partial byte).
- break_det mid-frame, then a new sta_det frame -> first frame rx_eof with rx_frame_err=1; second frame decodes cleanly.
- fd_restart asserted mid-byte -> no rx_eof; next frame decodes from symbol 0; rx_count restarts at 0.
- IRDA_FIR_CRC_CHK_EN defined: payload 0x31..0x39 ("123456789") + FCS 0x26,0x39,0xF4,0xCB -> rx_crc_err=0. Same frame with a flipped payload bit -> rx_crc_err=1.
